// File: rtl/config_controller.sv
// Config-register write/verify/readback controller: one request at a time.
// Writes pulse a one-hot slot enable, then read the slot back to confirm the value took.
module config_controller #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_data,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_err,
    output logic [NUM_REGS-1:0]            config_we,
    output logic [DATA_WIDTH-1:0]          config_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rd_data,
    output logic [7:0]                     err_count
);

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, READ, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    state_t                state, state_nx;
    req_t                  req_q;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] slot_val;

    assign addr_ok    = (int'(req_q.addr) < NUM_REGS);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Out-of-range addresses select nothing, so slot_val stays 0.
    always_comb begin
        slot_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(req_q.addr) == i)
                slot_val = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_we
        assign config_we[g] = (state == WRITE) && (int'(req_q.addr) == g);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_write ? WRITE : READ;
            WRITE:   state_nx = VERIFY;
            VERIFY:  state_nx = RESP;
            READ:    state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            req_q       <= '0;
            config_data <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    req_q    <= '{addr: req_addr, data: req_data};
                    resp_err <= 1'b0;
                    if (req_write) config_data <= req_data;
                end
                WRITE: if (!addr_ok) resp_err <= 1'b1;
                // Slot has taken the WRITE-cycle enable by now, so rd_data reflects it.
                VERIFY: begin
                    resp_data <= addr_ok ? slot_val : '0;
                    if (!addr_ok || slot_val != req_q.data) resp_err <= 1'b1;
                end
                READ: begin
                    resp_data <= addr_ok ? slot_val : '0;
                    if (!addr_ok) resp_err <= 1'b1;
                end
                RESP: if (resp_ready && resp_err && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_controller.sv
// Directed bench for config_controller; a small slot-register model feeds rd_data back.
module tb_config_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_addr;
    logic [3:0]  req_data;
    logic        resp_valid, resp_ready, resp_err;
    logic [3:0]  resp_data;
    logic [3:0]  config_we;
    logic [3:0]  config_data;
    logic [15:0] rd_data;
    logic [7:0]  err_count;

    logic [3:0]  slot_q [4];
    logic        stuck3;
    int          n_chk = 0;
    int          n_pass = 0;

    config_controller dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .config_we(config_we), .config_data(config_data),
        .rd_data(rd_data), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    // Slot registers the controller configures; slot 3 can be forced to read 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q[0] <= 4'h0; slot_q[1] <= 4'h5; slot_q[2] <= 4'h0; slot_q[3] <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (config_we[i]) slot_q[i] <= config_data;
        end
    end

    always_comb begin
        rd_data = {(stuck3 ? 4'h0 : slot_q[3]), slot_q[2], slot_q[1], slot_q[0]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full transaction with resp_ready held high; checks every cycle of it.
    task automatic txn(input logic wr, input logic [1:0] a, input logic [3:0] d,
                       input logic [3:0] exp_d, input logic exp_e, input logic [7:0] exp_cnt);
        logic [3:0] we_exp;
        we_exp = 4'b0001 << a;
        @(negedge CLK);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
        @(negedge CLK);
        req_valid = 1'b0;
        if (wr) begin
            chk("write_we", config_we, we_exp);
            chk("write_cfg_data", config_data, d);
            chk("write_no_resp", resp_valid, 0);
            @(negedge CLK);
            chk("verify_we_off", config_we, 0);
            chk("verify_no_resp", resp_valid, 0);
        end else begin
            chk("read_we_off", config_we, 0);
            chk("read_no_resp", resp_valid, 0);
        end
        @(negedge CLK);
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", resp_err, exp_e);
        chk("resp_req_ready", req_ready, 0);
        @(negedge CLK);
        chk("resp_done", resp_valid, 0);
        chk("err_count", err_count, exp_cnt);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        resp_ready = 1'b1; stuck3 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_we", config_we, 0);
        chk("rst_cfg_data", config_data, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_req_ready", req_ready, 1);
        RESET = 1'b0;

        // Write that sticks, then a plain readback.
        txn(1'b1, 2'd2, 4'hA, 4'hA, 1'b0, 8'd0);
        chk("slot2_written", slot_q[2], 4'hA);
        txn(1'b0, 2'd1, 4'hF, 4'h5, 1'b0, 8'd0);

        // Verify failure on a stuck slot.
        stuck3 = 1'b1;
        chk("err_count_pre", err_count, 0);
        txn(1'b1, 2'd3, 4'h7, 4'h0, 1'b1, 8'd1);

        // Backpressure: response held, stray request refused.
        resp_ready = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_data = 4'h3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, 4'hA);
            chk("bp_err", resp_err, 0);
            chk("bp_req_ready", req_ready, 0);
            @(negedge CLK);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge CLK);
        chk("bp_released", resp_valid, 0);
        chk("bp_no_stray_we", config_we, 0);
        chk("bp_err_count", err_count, 1);
        chk("bp_slot0", slot_q[0], 4'h0);

        // Reset during the WRITE cycle abandons the transaction.
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_data = 4'hC;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("mid_write_we", config_we, 4'b0001);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("mid_rst_we", config_we, 0);
        chk("mid_rst_err_count", err_count, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_resp", resp_valid, 0);
            chk("mid_rst_no_we", config_we, 0);
            chk("mid_rst_req_ready", req_ready, 1);
            @(negedge CLK);
        end

        // 256 verify failures: count climbs to 255 and stays there.
        stuck3 = 1'b1;
        for (int k = 1; k <= 256; k++)
            txn(1'b1, 2'd3, 4'h7, 4'h0, 1'b1, (k > 255) ? 8'd255 : 8'(k));
        chk("err_count_sat", err_count, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
